// File: rtl/cgra_context_sequencer_if.sv
// Config stream in from DMA/host and context-memory write port out to the PEs.
// master = sequencer side, slave = host/fabric side.
interface cgra_context_sequencer_if #(
    parameter int PC_WIDTH = 4
);
    logic [63:0]         cfg_in_data;
    logic                cfg_in_valid;
    logic                cfg_in_ready;
    logic [PC_WIDTH-1:0] cfg_wr_addr;
    logic [63:0]         cfg_wr_data;
    logic                cfg_wr_en;

    modport master (
        input  cfg_in_data,
        input  cfg_in_valid,
        output cfg_in_ready,
        output cfg_wr_addr,
        output cfg_wr_data,
        output cfg_wr_en
    );

    modport slave (
        output cfg_in_data,
        output cfg_in_valid,
        input  cfg_in_ready,
        input  cfg_wr_addr,
        input  cfg_wr_data,
        input  cfg_wr_en
    );
endinterface

// File: rtl/cgra_context_sequencer.sv
// CGRA tile-group context loader and context_pc stepper with host busy/done.
// Optional CTX_SEQ_PERF_EN adds saturating RUN / stalled-RUN cycle counters.
module cgra_context_sequencer #(
    parameter int PC_WIDTH      = 4,
    parameter int CONTEXT_DEPTH = 16,
    parameter int ITER_WIDTH    = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    input  logic                  abort_i,
    input  logic                  load_en_i,
    input  logic [PC_WIDTH-1:0]   num_ctx_i,
    input  logic [ITER_WIDTH-1:0] iter_count_i,
    cgra_context_sequencer_if.master cfg,
    input  logic                  stall_req_i,
    output logic [PC_WIDTH-1:0]   context_pc_o,
    output logic                  global_stall_o,
    output logic                  busy_o,
    output logic                  done_o
`ifdef CTX_SEQ_PERF_EN
    ,
    output logic [31:0]           perf_run_cycles_o,
    output logic [31:0]           perf_stall_cycles_o
`endif
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SETTLE,
        S_RUN,
        S_DONE
    } state_e;

    localparam logic [31:0] MAX_L = 32'(CONTEXT_DEPTH - 1);

    state_e                state_q;
    logic [PC_WIDTH-1:0]   last_q;
    logic [PC_WIDTH-1:0]   load_cnt_q;
    logic [PC_WIDTH-1:0]   pc_q;
    logic [PC_WIDTH-1:0]   wr_addr_q;
    logic [63:0]           wr_data_q;
    logic                  wr_en_q;
    logic                  done_q;
    logic [ITER_WIDTH-1:0] n_q;
    logic [ITER_WIDTH-1:0] iter_q;

    logic [PC_WIDTH-1:0]   last_d;
    logic                  accept_start;
    logic                  pc_last;
    logic                  iter_last;

    always_comb begin
        last_d = num_ctx_i;
        if (32'(num_ctx_i) > MAX_L) begin
            last_d = MAX_L[PC_WIDTH-1:0];
        end
    end

    assign accept_start = (state_q == S_IDLE) & start_i & ~abort_i;
    assign pc_last      = (pc_q == last_q);
    assign iter_last    = (iter_q == (n_q - ITER_WIDTH'(1)));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            last_q     <= '0;
            load_cnt_q <= '0;
            pc_q       <= '0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            wr_en_q    <= 1'b0;
            done_q     <= 1'b0;
            n_q        <= '0;
            iter_q     <= '0;
        end else if (abort_i && state_q != S_IDLE) begin
            // A word handshaken this cycle is consumed but never written.
            state_q <= S_IDLE;
            wr_en_q <= 1'b0;
            done_q  <= 1'b0;
            pc_q    <= '0;
        end else begin
            wr_en_q <= 1'b0;
            done_q  <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (accept_start) begin
                        last_q     <= last_d;
                        n_q        <= iter_count_i;
                        load_cnt_q <= '0;
                        iter_q     <= '0;
                        pc_q       <= '0;
                        if (load_en_i) begin
                            state_q <= S_LOAD;
                        end else if (iter_count_i == '0) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= S_RUN;
                        end
                    end
                end
                S_LOAD: begin
                    if (cfg.cfg_in_valid) begin
                        wr_en_q    <= 1'b1;
                        wr_addr_q  <= load_cnt_q;
                        wr_data_q  <= cfg.cfg_in_data;
                        load_cnt_q <= load_cnt_q + PC_WIDTH'(1);
                        if (load_cnt_q == last_q) begin
                            state_q <= S_SETTLE;
                        end
                    end
                end
                S_SETTLE: begin
                    if (n_q == '0) begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                    end else begin
                        state_q <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (!stall_req_i) begin
                        if (pc_last) begin
                            pc_q <= '0;
                            if (iter_last) begin
                                state_q <= S_DONE;
                                done_q  <= 1'b1;
                            end else begin
                                iter_q <= iter_q + ITER_WIDTH'(1);
                            end
                        end else begin
                            pc_q <= pc_q + PC_WIDTH'(1);
                        end
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    pc_q    <= '0;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign cfg.cfg_in_ready = (state_q == S_LOAD);
    assign cfg.cfg_wr_addr  = wr_addr_q;
    assign cfg.cfg_wr_data  = wr_data_q;
    assign cfg.cfg_wr_en    = wr_en_q;

    assign context_pc_o   = pc_q;
    assign global_stall_o = (state_q != S_RUN) | stall_req_i;
    assign busy_o         = (state_q != S_IDLE);
    assign done_o         = done_q;

`ifdef CTX_SEQ_PERF_EN
    logic [31:0] perf_run_q;
    logic [31:0] perf_stall_q;

    always_ff @(posedge clk) begin
        if (rst || accept_start) begin
            perf_run_q   <= '0;
            perf_stall_q <= '0;
        end else if (state_q == S_RUN) begin
            if (perf_run_q != '1) begin
                perf_run_q <= perf_run_q + 32'd1;
            end
            if (stall_req_i && perf_stall_q != '1) begin
                perf_stall_q <= perf_stall_q + 32'd1;
            end
        end
    end

    assign perf_run_cycles_o   = perf_run_q;
    assign perf_stall_cycles_o = perf_stall_q;
`endif

endmodule

// File: tb/tb_cgra_context_sequencer.sv
// Randomized scoreboard bench for cgra_context_sequencer: expected write,
// context_pc and done events are queued at issue and checked by a monitor.
module tb_cgra_context_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        load_en = 1'b0;
    logic [3:0]  num_ctx = '0;
    logic [15:0] iter_count = '0;
    logic        stall_req = 1'b0;
    logic [3:0]  context_pc;
    logic        global_stall;
    logic        busy;
    logic        done;
`ifdef CTX_SEQ_PERF_EN
    logic [31:0] perf_run;
    logic [31:0] perf_stall;
`endif

    always #5 clk = ~clk;

    cgra_context_sequencer_if #(.PC_WIDTH(4)) cfg ();

    cgra_context_sequencer #(
        .PC_WIDTH(4),
        .CONTEXT_DEPTH(16),
        .ITER_WIDTH(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start_i(start),
        .abort_i(abort),
        .load_en_i(load_en),
        .num_ctx_i(num_ctx),
        .iter_count_i(iter_count),
        .cfg(cfg),
        .stall_req_i(stall_req),
        .context_pc_o(context_pc),
        .global_stall_o(global_stall),
        .busy_o(busy),
        .done_o(done)
`ifdef CTX_SEQ_PERF_EN
        ,
        .perf_run_cycles_o(perf_run),
        .perf_stall_cycles_o(perf_stall)
`endif
    );

    typedef enum int {EV_WR, EV_PC, EV_DONE} ev_kind_e;
    typedef struct {
        ev_kind_e    kind;
        logic [3:0]  a;
        logic [63:0] d;
    } ev_t;

    ev_t exp_q[$];
    int  n_checks = 0;
    int  n_fail = 0;
    bit  done_pend = 1'b0;

    function automatic void chk(bit ok, string name,
                                logic [63:0] act, logic [63:0] expv);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endfunction

    function automatic void push(ev_kind_e k, logic [3:0] a, logic [63:0] d);
        ev_t e;
        e.kind = k;
        e.a    = a;
        e.d    = d;
        exp_q.push_back(e);
    endfunction

    // Reference model: a pass is contexts 0..L in order, repeated N times.
    function automatic void push_run(logic [3:0] L, logic [15:0] N);
        for (int n = 0; n < int'(N); n++)
            for (int p = 0; p <= int'(L); p++)
                push(EV_PC, 4'(p), 64'd0);
        push(EV_DONE, 4'd0, 64'd0);
    endfunction

    always @(negedge clk) begin : monitor
        ev_t e;
        if (!rst) begin
            if (done_pend) begin
                chk(busy == 1'b0, "busy_after_done", 64'(busy), 64'd0);
                done_pend = 1'b0;
            end
            if (cfg.cfg_wr_en) begin
                if (exp_q.size() == 0) begin
                    chk(1'b0, "spurious_write", 64'(cfg.cfg_wr_addr), 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk(e.kind == EV_WR, "write_order", 64'(e.kind), 64'(EV_WR));
                    chk(cfg.cfg_wr_addr == e.a, "wr_addr",
                        64'(cfg.cfg_wr_addr), 64'(e.a));
                    chk(cfg.cfg_wr_data == e.d, "wr_data",
                        cfg.cfg_wr_data, e.d);
                end
            end
            if (!global_stall) begin
                if (exp_q.size() == 0) begin
                    chk(1'b0, "spurious_run_cycle", 64'(context_pc), 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk(e.kind == EV_PC, "run_order", 64'(e.kind), 64'(EV_PC));
                    chk(context_pc == e.a, "context_pc",
                        64'(context_pc), 64'(e.a));
                end
            end
            if (done) begin
                if (exp_q.size() == 0) begin
                    chk(1'b0, "spurious_done", 64'd1, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk(e.kind == EV_DONE, "done_order",
                        64'(e.kind), 64'(EV_DONE));
                end
                chk(global_stall == 1'b1, "done_stall", 64'(global_stall), 64'd1);
                done_pend = 1'b1;
            end
            if (stall_req && exp_q.size() > 0 && exp_q[0].kind == EV_PC) begin
                chk(context_pc == exp_q[0].a, "pc_hold",
                    64'(context_pc), 64'(exp_q[0].a));
                chk(global_stall == 1'b1, "stall_out", 64'(global_stall), 64'd1);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_txn(input bit le, input logic [3:0] L,
                           input logic [15:0] N, input bit gaps,
                           input bit fixed_data, input int stall_mode,
                           input int abort_k, input bit start_in_run);
        logic [63:0] w[16];
        int cyc;
        for (int i = 0; i <= int'(L); i++)
            w[i] = fixed_data ? 64'(8'hA0 + i) : {$urandom, $urandom};
        if (le)
            for (int i = 0; i <= int'(L); i++)
                if (abort_k < 0 || i < abort_k)
                    push(EV_WR, 4'(i), w[i]);
        if (abort_k < 0) push_run(L, N);
        start      = 1'b1;
        load_en    = le;
        num_ctx    = L;
        iter_count = N;
        tick();
        start = 1'b0;
        if (le) begin
            for (int i = 0; i <= int'(L); i++) begin
                if (gaps) repeat ($urandom % 3) tick();
                cfg.cfg_in_valid = 1'b1;
                cfg.cfg_in_data  = w[i];
                if (i == abort_k) abort = 1'b1;
                tick();
                cfg.cfg_in_valid = 1'b0;
                cfg.cfg_in_data  = {$urandom, $urandom};
                if (i == abort_k) begin
                    abort = 1'b0;
                    chk(busy == 1'b0, "abort_busy", 64'(busy), 64'd0);
                    chk(cfg.cfg_in_ready == 1'b0, "abort_ready",
                        64'(cfg.cfg_in_ready), 64'd0);
                    chk(exp_q.size() == 0, "abort_pending",
                        64'(exp_q.size()), 64'd0);
                    exp_q.delete();
                    return;
                end
            end
        end
        cyc = 0;
        while ((exp_q.size() != 0 || busy) && cyc < 3000) begin
            if (stall_mode == 1)
                stall_req = ($urandom % 4) == 0;
            else
                stall_req = (stall_mode == 2) && cyc >= 2 && cyc < 5;
            if (start_in_run && busy && ($urandom % 6) == 0) begin
                start      = 1'b1;
                num_ctx    = 4'($urandom);
                iter_count = 16'($urandom);
            end
            tick();
            start = 1'b0;
            cyc++;
        end
        stall_req = 1'b0;
        chk(cyc < 3000, "txn_timeout", 64'(cyc), 64'd3000);
        exp_q.delete();
    endtask

    initial begin
        cfg.cfg_in_valid = 1'b0;
        cfg.cfg_in_data  = '0;
        repeat (2) tick();
        rst = 1'b0;
        chk(busy == 1'b0, "reset_busy", 64'(busy), 64'd0);
        chk(cfg.cfg_in_ready == 1'b0, "reset_ready", 64'(cfg.cfg_in_ready), 64'd0);
        chk(global_stall == 1'b1, "reset_stall", 64'(global_stall), 64'd1);
        chk(context_pc == 4'd0, "reset_pc", 64'(context_pc), 64'd0);
        chk(cfg.cfg_wr_en == 1'b0, "reset_wr_en", 64'(cfg.cfg_wr_en), 64'd0);
        chk(done == 1'b0, "reset_done", 64'(done), 64'd0);

        // Load 4 words back-to-back, 2 passes, no stalls.
        run_txn(1'b1, 4'd3, 16'd2, 1'b0, 1'b1, 0, -1, 1'b0);

        // Same with 3 stalled cycles while pc=1.
        run_txn(1'b1, 4'd3, 16'd2, 1'b0, 1'b1, 2, -1, 1'b0);
`ifdef CTX_SEQ_PERF_EN
        chk(perf_run == 32'd11, "perf_run", 64'(perf_run), 64'd11);
        chk(perf_stall == 32'd3, "perf_stall", 64'(perf_stall), 64'd3);
`endif

        // Zero iterations: done the cycle after start, idle the next.
        push(EV_DONE, 4'd0, 64'd0);
        start      = 1'b1;
        load_en    = 1'b0;
        num_ctx    = 4'd5;
        iter_count = 16'd0;
        tick();
        start = 1'b0;
        chk(done == 1'b1, "zero_iter_done", 64'(done), 64'd1);
        tick();
        chk(busy == 1'b0, "zero_iter_idle", 64'(busy), 64'd0);

        // Abort mid-load, then a normal restart.
        run_txn(1'b1, 4'd3, 16'd2, 1'b0, 1'b1, 0, 2, 1'b0);
        tick();
        run_txn(1'b1, 4'd3, 16'd2, 1'b1, 1'b0, 0, -1, 1'b0);

        // Single context, starts during RUN must be ignored.
        run_txn(1'b0, 4'd0, 16'd3, 1'b0, 1'b0, 0, -1, 1'b1);

        // Start together with abort in IDLE is ignored.
        start      = 1'b1;
        abort      = 1'b1;
        load_en    = 1'b1;
        iter_count = 16'd4;
        tick();
        start = 1'b0;
        abort = 1'b0;
        chk(busy == 1'b0, "start_abort_idle", 64'(busy), 64'd0);

        // Abort during RUN.
        push_run(4'd3, 16'd10);
        start      = 1'b1;
        load_en    = 1'b0;
        num_ctx    = 4'd3;
        iter_count = 16'd10;
        tick();
        start = 1'b0;
        repeat (6) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        exp_q.delete();
        chk(busy == 1'b0, "run_abort_busy", 64'(busy), 64'd0);
        chk(context_pc == 4'd0, "run_abort_pc", 64'(context_pc), 64'd0);
        repeat (3) tick();

        // Reset held 2 cycles mid-RUN.
        push_run(4'd2, 16'd100);
        start      = 1'b1;
        num_ctx    = 4'd2;
        iter_count = 16'd100;
        tick();
        start = 1'b0;
        repeat (5) tick();
        rst = 1'b1;
        repeat (2) tick();
        chk(context_pc == 4'd0, "rst_pc", 64'(context_pc), 64'd0);
        chk(global_stall == 1'b1, "rst_stall", 64'(global_stall), 64'd1);
        chk(cfg.cfg_wr_en == 1'b0, "rst_wr_en", 64'(cfg.cfg_wr_en), 64'd0);
        chk(busy == 1'b0, "rst_busy", 64'(busy), 64'd0);
        chk(done == 1'b0, "rst_done", 64'(done), 64'd0);
        exp_q.delete();
        rst = 1'b0;
        tick();

        // Randomized transactions with gaps, stalls, aborts and stray starts.
        for (int t = 0; t < 40; t++) begin
            bit          le;
            logic [3:0]  L;
            logic [15:0] N;
            int          ak;
            le = 1'($urandom);
            L  = 4'($urandom);
            N  = 16'($urandom % 4);
            ak = (le && ($urandom % 6) == 0) ? int'($urandom_range(0, L)) : -1;
            run_txn(le, L, N, 1'b1, 1'b0, 1, ak, 1'b1);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
